mac_array_ctrl: RTL



---
 rtl/mac_pkg.sv | 20 ++
 rtl/ctrl_cnt.sv | 28 ++
 rtl/mac_array_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC array sequencer: FSM states, column
// instruction encodings and default array dimensions.
package mac_pkg;

  localparam int unsigned BW      = 4;
  localparam int unsigned BW_PSUM = 16;
  localparam int unsigned COL     = 8;

  localparam logic [1:0] INST_NOP  = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    EXEC  = 2'd2,
    DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/ctrl_cnt.sv
// Loadable down-counter with a zero flag; times both the key-load and drain
// phases. Load wins over decrement, and the count stops at zero.
module ctrl_cnt #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mac_array_ctrl.sv
// Sequencer for the MAC array: key load, query streaming with output-FIFO
// backpressure, then a fixed drain before signalling done.
module mac_array_ctrl
  import mac_pkg::*;
#(
  parameter int unsigned col       = COL,
  parameter int unsigned aw        = 6,
  parameter int unsigned load_len  = 10,
  parameter int unsigned drain_len = col + 2,
  parameter int unsigned q_base    = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [aw-1:0] num_q,
  input  logic          ofifo_full,
  output logic          mem_cen,
  output logic [aw-1:0] mem_addr,
  output logic [1:0]    inst,
  output logic          busy,
  output logic          done,
  output logic [aw-1:0] q_cnt
);

  localparam int unsigned CNT_MAX = (load_len > drain_len) ? load_len : drain_len;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] LOAD_INIT  = CW'(load_len - 1);
  localparam logic [CW-1:0] DRAIN_INIT = CW'(drain_len - 1);
  localparam logic [aw-1:0] QB  = aw'(q_base);
  localparam logic [aw-1:0] ONE = aw'(1);

  state_e        state_q, state_d;
  logic [aw-1:0] addr_q, addr_d;
  logic [aw-1:0] qcnt_q, qcnt_d;
  logic [aw-1:0] numq_q, numq_d;
  logic [1:0]    inst_q, inst_d;
  logic          done_q, done_d;
  logic          issue;
  logic          cnt_load;
  logic [CW-1:0] cnt_val;
  logic          cnt_zero;

  ctrl_cnt #(.W(CW)) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .load_i (cnt_load),
    .dec_i  ((state_q == LOAD) || (state_q == DRAIN)),
    .val_i  (cnt_val),
    .zero_o (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    qcnt_d   = qcnt_q;
    numq_d   = numq_q;
    inst_d   = INST_NOP;
    done_d   = 1'b0;
    issue    = 1'b0;
    cnt_load = 1'b0;
    cnt_val  = DRAIN_INIT;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = LOAD;
          numq_d   = num_q;
          addr_d   = '0;
          qcnt_d   = '0;
          cnt_load = 1'b1;
          cnt_val  = LOAD_INIT;
        end
      end
      LOAD: begin
        issue  = 1'b1;
        inst_d = INST_LOAD;
        addr_d = addr_q + ONE;
        if (cnt_zero) begin
          // Pre-point at the query region; the timer is reloaded for drain
          // here and simply idles through EXEC.
          addr_d   = QB;
          cnt_load = 1'b1;
          state_d  = (numq_q != '0) ? EXEC : DRAIN;
        end
      end
      EXEC: begin
        if (!ofifo_full) begin
          issue  = 1'b1;
          inst_d = INST_EXEC;
          addr_d = addr_q + ONE;
          qcnt_d = qcnt_q + ONE;
          if ((qcnt_q + ONE) == numq_q) begin
            state_d  = DRAIN;
            cnt_load = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (cnt_zero) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      qcnt_q  <= '0;
      numq_q  <= '0;
      inst_q  <= INST_NOP;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      qcnt_q  <= qcnt_d;
      numq_q  <= numq_d;
      inst_q  <= inst_d;
      done_q  <= done_d;
    end
  end

  assign mem_cen  = ~issue;
  assign mem_addr = addr_q;
  assign inst     = inst_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign q_cnt    = qcnt_q;

endmodule
